// File: rtl/vga_sprite_overlay.sv
// vga_sprite_overlay
//   Pixel-generation stage placed after the VGA timing controller. Overlays one
//   SPR_W x SPR_H sprite, read from an external synchronous BRAM, onto a solid
//   background colour. Output RGB444 and HS/VS are delay-matched, 3 cycles after
//   the coordinates are presented. Sprite moves are accepted through a
//   valid/ready handshake into a single pending slot and applied only on a VSin
//   falling edge, so a frame never shows two positions (no tearing).
//
//   Optional feature: define OVERLAY_BORDER_EN to draw a one-pixel BORDER_COLOR
//   frame around the 640x480 visible area (border overrides the sprite).
//
// Ports
//   ckVideo, rstVideoN       pixel clock, async active-low reset
//   adrHor, adrVer           pixel column / line from the timing controller
//   flgActiveVideo           1 = visible pixel
//   HSin, VSin               active-low syncs from the timing controller
//   bgColor                  background RGB444
//   posX, posY, posValid     sprite position request
//   posReady                 request slot free
//   sprAddr, sprData         sprite BRAM port (data 1 cycle after address)
//   rgbOut, HS, VS           delayed pixel colour and syncs to the pins
//   frameTick                1-cycle pulse on each VSin falling edge

module vga_sprite_overlay #(
    parameter int unsigned SPR_W        = 32,
    parameter int unsigned SPR_H        = 32,
    parameter logic [11:0] TRANSP       = 12'hF0F,
    parameter logic [9:0]  RST_X        = 10'd304,
    parameter logic [9:0]  RST_Y        = 10'd224,
    parameter logic [11:0] BORDER_COLOR = 12'hFFF
) (
    input  logic        ckVideo,
    input  logic        rstVideoN,
    input  logic [9:0]  adrHor,
    input  logic [9:0]  adrVer,
    input  logic        flgActiveVideo,
    input  logic        HSin,
    input  logic        VSin,
    input  logic [11:0] bgColor,
    input  logic [9:0]  posX,
    input  logic [9:0]  posY,
    input  logic        posValid,
    output logic        posReady,
    output logic [11:0] sprAddr,
    input  logic [11:0] sprData,
    output logic [11:0] rgbOut,
    output logic        HS,
    output logic        VS,
    output logic        frameTick
);

    localparam int unsigned XW = $clog2(SPR_W);
    localparam int unsigned YW = $clog2(SPR_H);

    // Position state
    logic [9:0]  act_x_q, act_x_d, act_y_q, act_y_d;
    logic [9:0]  pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic        pending_q, pending_d;
    logic        frame_tick_q, frame_tick_d;

    // S1
    logic        active_s1_q, active_s1_d;
    logic        hit_s1_q, hit_s1_d;
    logic        hs_s1_q, hs_s1_d;
    logic        vs_s1_q, vs_s1_d;
    logic [11:0] spr_addr_q, spr_addr_d;

    // S2
    logic        active_s2_q, active_s2_d;
    logic        hit_s2_q, hit_s2_d;
    logic        hs_s2_q, hs_s2_d;
    logic        vs_s2_q, vs_s2_d;
    logic [11:0] bg_s2_q, bg_s2_d;

    // OUT
    logic [11:0] rgb_q, rgb_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;

    logic          hit_x, hit_y, vs_fall, accept;
    logic [XW-1:0] dx;
    logic [YW-1:0] dy;

`ifdef OVERLAY_BORDER_EN
    logic border_s1_q, border_s1_d;
    logic border_s2_q, border_s2_d;
`else
    logic [11:0] unused_border_color;
    assign unused_border_color = BORDER_COLOR;
`endif

    always_comb begin
        // 11-bit compares so a sprite near the right/bottom edge cannot wrap to 0.
        hit_x = ({1'b0, adrHor} >= {1'b0, act_x_q}) &&
                ({1'b0, adrHor} <  ({1'b0, act_x_q} + 11'(SPR_W)));
        hit_y = ({1'b0, adrVer} >= {1'b0, act_y_q}) &&
                ({1'b0, adrVer} <  ({1'b0, act_y_q} + 11'(SPR_H)));
        dx    = XW'(adrHor - act_x_q);
        dy    = YW'(adrVer - act_y_q);

        // VS edge detector reuses the S1 copy of VSin as the previous sample.
        vs_fall = vs_s1_q && !VSin;
        accept  = posValid && !pending_q;

        pend_x_d  = pend_x_q;
        pend_y_d  = pend_y_q;
        pending_d = pending_q;
        act_x_d   = act_x_q;
        act_y_d   = act_y_q;
        if (vs_fall && pending_q) begin
            act_x_d   = pend_x_q;
            act_y_d   = pend_y_q;
            pending_d = 1'b0;
        end else if (accept) begin
            pend_x_d  = posX;
            pend_y_d  = posY;
            pending_d = 1'b1;
        end
        frame_tick_d = vs_fall;

        // S1
        active_s1_d = flgActiveVideo;
        hit_s1_d    = hit_x && hit_y;
        hs_s1_d     = HSin;
        vs_s1_d     = VSin;
        spr_addr_d  = spr_addr_q;
        if (hit_x && hit_y) begin
            spr_addr_d = 12'({dy, dx});
        end
`ifdef OVERLAY_BORDER_EN
        border_s1_d = (adrHor == 10'd0) || (adrHor == 10'd639) ||
                      (adrVer == 10'd0) || (adrVer == 10'd479);
        border_s2_d = border_s1_q;
`endif

        // S2
        active_s2_d = active_s1_q;
        hit_s2_d    = hit_s1_q;
        hs_s2_d     = hs_s1_q;
        vs_s2_d     = vs_s1_q;
        bg_s2_d     = bgColor;

        // OUT: colour priority blank > border > opaque sprite > background
        hs_d = hs_s2_q;
        vs_d = vs_s2_q;
        if (!active_s2_q) begin
            rgb_d = 12'h000;
`ifdef OVERLAY_BORDER_EN
        end else if (border_s2_q) begin
            rgb_d = BORDER_COLOR;
`endif
        end else if (hit_s2_q && (sprData != TRANSP)) begin
            rgb_d = sprData;
        end else begin
            rgb_d = bg_s2_q;
        end
    end

    always_ff @(posedge ckVideo or negedge rstVideoN) begin
        if (!rstVideoN) begin
            act_x_q      <= RST_X;
            act_y_q      <= RST_Y;
            pend_x_q     <= 10'd0;
            pend_y_q     <= 10'd0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            active_s1_q  <= 1'b0;
            hit_s1_q     <= 1'b0;
            hs_s1_q      <= 1'b1;
            vs_s1_q      <= 1'b1;
            spr_addr_q   <= 12'd0;
            active_s2_q  <= 1'b0;
            hit_s2_q     <= 1'b0;
            hs_s2_q      <= 1'b1;
            vs_s2_q      <= 1'b1;
            bg_s2_q      <= 12'h000;
            rgb_q        <= 12'h000;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
`ifdef OVERLAY_BORDER_EN
            border_s1_q  <= 1'b0;
            border_s2_q  <= 1'b0;
`endif
        end else begin
            act_x_q      <= act_x_d;
            act_y_q      <= act_y_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            pending_q    <= pending_d;
            frame_tick_q <= frame_tick_d;
            active_s1_q  <= active_s1_d;
            hit_s1_q     <= hit_s1_d;
            hs_s1_q      <= hs_s1_d;
            vs_s1_q      <= vs_s1_d;
            spr_addr_q   <= spr_addr_d;
            active_s2_q  <= active_s2_d;
            hit_s2_q     <= hit_s2_d;
            hs_s2_q      <= hs_s2_d;
            vs_s2_q      <= vs_s2_d;
            bg_s2_q      <= bg_s2_d;
            rgb_q        <= rgb_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
`ifdef OVERLAY_BORDER_EN
            border_s1_q  <= border_s1_d;
            border_s2_q  <= border_s2_d;
`endif
        end
    end

    assign posReady  = !pending_q;
    assign sprAddr   = spr_addr_q;
    assign rgbOut    = rgb_q;
    assign HS        = hs_q;
    assign VS        = vs_q;
    assign frameTick = frame_tick_q;

endmodule

// File: tb/tb_vga_sprite_overlay.sv
// Directed testbench for vga_sprite_overlay with a synchronous sprite ROM model.

module tb_vga_sprite_overlay;

`ifdef OVERLAY_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif
    localparam logic [11:0] BG  = 12'h00F;
    localparam logic [11:0] SPR = 12'h0F0;
    localparam logic [11:0] BRD = 12'hFFF;

    logic        ckVideo = 1'b0;
    logic        rstVideoN = 1'b0;
    logic [9:0]  adrHor = 10'd700, adrVer = 10'd500;
    logic        flgActiveVideo = 1'b0;
    logic        HSin = 1'b1, VSin = 1'b1;
    logic [11:0] bgColor = BG;
    logic [9:0]  posX = 10'd0, posY = 10'd0;
    logic        posValid = 1'b0;
    logic        posReady;
    logic [11:0] sprAddr;
    logic [11:0] sprData = 12'h000;
    logic [11:0] rgbOut;
    logic        HS, VS, frameTick;

    logic [11:0] rom [0:4095];
    int n_cmp = 0;
    int n_err = 0;

    vga_sprite_overlay dut (
        .ckVideo(ckVideo), .rstVideoN(rstVideoN),
        .adrHor(adrHor), .adrVer(adrVer), .flgActiveVideo(flgActiveVideo),
        .HSin(HSin), .VSin(VSin), .bgColor(bgColor),
        .posX(posX), .posY(posY), .posValid(posValid), .posReady(posReady),
        .sprAddr(sprAddr), .sprData(sprData),
        .rgbOut(rgbOut), .HS(HS), .VS(VS), .frameTick(frameTick)
    );

    always #5 ckVideo = ~ckVideo;

    // Synchronous BRAM: data one cycle after address
    always @(posedge ckVideo) sprData <= rom[sprAddr];

    task automatic step();
        @(posedge ckVideo);
        #1;
    endtask

    task automatic set_pix(input logic [9:0] h, input logic [9:0] v, input logic a);
        adrHor = h;
        adrVer = v;
        flgActiveVideo = a;
    endtask

    // Present one pixel, then blanking, and return the colour 3 cycles later.
    task automatic run_pix(input logic [9:0] h, input logic [9:0] v, input logic a,
                           output logic [11:0] obs);
        set_pix(h, v, a);
        step();
        set_pix(10'd700, 10'd500, 1'b0);
        step();
        step();
        obs = rgbOut;
    endtask

    task automatic vs_pulse(output logic tick);
        VSin = 1'b0;
        set_pix(10'd700, 10'd500, 1'b0);
        step();
        tick = frameTick;
        VSin = 1'b1;
        step();
    endtask

    task automatic move_to(input logic [9:0] x, input logic [9:0] y);
        logic t;
        posX = x;
        posY = y;
        posValid = 1'b1;
        step();
        posValid = 1'b0;
        vs_pulse(t);
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (rgbOut !== 12'h000) begin n_err++; $display("FAIL reset_rgb: got %h want 000", rgbOut); end
        n_cmp++; if (HS !== 1'b1) begin n_err++; $display("FAIL reset_hs: got %b want 1", HS); end
        n_cmp++; if (VS !== 1'b1) begin n_err++; $display("FAIL reset_vs: got %b want 1", VS); end
        n_cmp++; if (frameTick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b want 0", frameTick); end
        n_cmp++; if (sprAddr !== 12'd0) begin n_err++; $display("FAIL reset_addr: got %h want 000", sprAddr); end
        n_cmp++; if (posReady !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", posReady); end
        @(negedge ckVideo);
        rstVideoN = 1'b1;
        step();
    endtask

    task automatic test_frame();
        logic [11:0] exp_rgb [48];
        logic        exp_hs [48];
        logic        exp_vs [48];
        logic [9:0]  ph [5] = '{10'd304, 10'd335, 10'd304, 10'd336, 10'd304};
        logic [9:0]  pv [5] = '{10'd223, 10'd255, 10'd256, 10'd255, 10'd224};
        logic [11:0] pe [5] = '{BG, SPR, BG, BG, SPR};
        logic [11:0] obs;
        logic        t;
        // Streamed line through the sprite, with blanking holes and sync toggles
        for (int k = 0; k < 50; k++) begin
            if (k < 48) begin
                logic [9:0] h;
                logic a;
                h = 10'(296 + k);
                a = (k % 11) != 10;
                set_pix(h, 10'd224, a);
                HSin = (k % 5) != 0;
                VSin = !(k >= 20 && k <= 22);
                exp_rgb[k] = !a ? 12'h000 : ((h >= 10'd304 && h <= 10'd335) ? SPR : BG);
                exp_hs[k] = HSin;
                exp_vs[k] = VSin;
            end else begin
                set_pix(10'd700, 10'd500, 1'b0);
                HSin = 1'b1;
                VSin = 1'b1;
            end
            step();
            if (k >= 2) begin
                n_cmp++; if (rgbOut !== exp_rgb[k-2]) begin n_err++; $display("FAIL frame_rgb[%0d]: got %h want %h", k-2, rgbOut, exp_rgb[k-2]); end
                n_cmp++; if (HS !== exp_hs[k-2]) begin n_err++; $display("FAIL frame_hs[%0d]: got %b want %b", k-2, HS, exp_hs[k-2]); end
                n_cmp++; if (VS !== exp_vs[k-2]) begin n_err++; $display("FAIL frame_vs[%0d]: got %b want %b", k-2, VS, exp_vs[k-2]); end
            end
        end
        for (int i = 0; i < 5; i++) begin
            run_pix(ph[i], pv[i], 1'b1, obs);
            n_cmp++; if (obs !== pe[i]) begin n_err++; $display("FAIL frame_pix(%0d,%0d): got %h want %h", ph[i], pv[i], obs, pe[i]); end
        end
        // Address = dy*32+dx for (305,225) -> 33
        set_pix(10'd305, 10'd225, 1'b1);
        step();
        n_cmp++; if (sprAddr !== 12'd33) begin n_err++; $display("FAIL frame_addr: got %0d want 33", sprAddr); end
        set_pix(10'd700, 10'd500, 1'b0);
        step();
        step();
        // VS edge with no request pending still ticks
        vs_pulse(t);
        n_cmp++; if (t !== 1'b1) begin n_err++; $display("FAIL frame_tick: got %b want 1", t); end
        n_cmp++; if (frameTick !== 1'b0) begin n_err++; $display("FAIL frame_tick_end: got %b want 0", frameTick); end
        n_cmp++; if (posReady !== 1'b1) begin n_err++; $display("FAIL frame_ready: got %b want 1", posReady); end
    endtask

    task automatic test_clip();
        logic [9:0]  ph [7] = '{10'd620, 10'd638, 10'd619, 10'd5, 10'd630, 10'd304, 10'd639};
        logic [9:0]  pv [7] = '{10'd470, 10'd478, 10'd470, 10'd475, 10'd5, 10'd224, 10'd479};
        logic [11:0] pe [7];
        logic [11:0] obs;
        logic        t;
        pe = '{SPR, SPR, BG, BG, BG, BG, (BORDER ? BRD : SPR)};
        posX = 10'd620;
        posY = 10'd470;
        posValid = 1'b1;
        step();
        posValid = 1'b0;
        n_cmp++; if (posReady !== 1'b0) begin n_err++; $display("FAIL clip_ready_low: got %b want 0", posReady); end
        run_pix(10'd304, 10'd224, 1'b1, obs);
        n_cmp++; if (obs !== SPR) begin n_err++; $display("FAIL clip_old_pos: got %h want %h", obs, SPR); end
        run_pix(10'd620, 10'd470, 1'b1, obs);
        n_cmp++; if (obs !== BG) begin n_err++; $display("FAIL clip_not_yet: got %h want %h", obs, BG); end
        vs_pulse(t);
        n_cmp++; if (t !== 1'b1) begin n_err++; $display("FAIL clip_tick: got %b want 1", t); end
        n_cmp++; if (posReady !== 1'b1) begin n_err++; $display("FAIL clip_ready_high: got %b want 1", posReady); end
        for (int i = 0; i < 7; i++) begin
            run_pix(ph[i], pv[i], 1'b1, obs);
            n_cmp++; if (obs !== pe[i]) begin n_err++; $display("FAIL clip_pix(%0d,%0d): got %h want %h", ph[i], pv[i], obs, pe[i]); end
        end
    endtask

    task automatic test_transparent();
        logic [9:0]  ph [5] = '{10'd0, 10'd1, 10'd1, 10'd2, 10'd3};
        logic [9:0]  pv [5] = '{10'd0, 10'd0, 10'd1, 10'd1, 10'd1};
        logic [11:0] pe [5];
        logic [11:0] obs;
        pe = '{(BORDER ? BRD : BG), (BORDER ? BRD : SPR), BG, 12'h123, SPR};
        rom[0]  = 12'hF0F;
        rom[33] = 12'hF0F;
        rom[34] = 12'h123;
        move_to(10'd0, 10'd0);
        for (int i = 0; i < 5; i++) begin
            run_pix(ph[i], pv[i], 1'b1, obs);
            n_cmp++; if (obs !== pe[i]) begin n_err++; $display("FAIL transp_pix(%0d,%0d): got %h want %h", ph[i], pv[i], obs, pe[i]); end
        end
    endtask

    task automatic test_border();
        logic [11:0] obs;
        rom[0]  = SPR;
        rom[33] = SPR;
        run_pix(10'd0, 10'd0, 1'b1, obs);
        n_cmp++; if (obs !== (BORDER ? BRD : SPR)) begin n_err++; $display("FAIL border_00: got %h want %h", obs, (BORDER ? BRD : SPR)); end
        run_pix(10'd1, 10'd1, 1'b1, obs);
        n_cmp++; if (obs !== SPR) begin n_err++; $display("FAIL border_11: got %h want %h", obs, SPR); end
        run_pix(10'd639, 10'd240, 1'b1, obs);
        n_cmp++; if (obs !== (BORDER ? BRD : BG)) begin n_err++; $display("FAIL border_right: got %h want %h", obs, (BORDER ? BRD : BG)); end
        run_pix(10'd0, 10'd0, 1'b0, obs);
        n_cmp++; if (obs !== 12'h000) begin n_err++; $display("FAIL border_blank: got %h want 000", obs); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] obs;
        logic        t;
        posX = 10'd100;
        posY = 10'd100;
        posValid = 1'b1;
        step();
        n_cmp++; if (posReady !== 1'b0) begin n_err++; $display("FAIL b2b_first_acc: got %b want 0", posReady); end
        posX = 10'd200;
        posY = 10'd200;
        run_pix(10'd100, 10'd100, 1'b1, obs);
        n_cmp++; if (obs !== BG) begin n_err++; $display("FAIL b2b_not_yet: got %h want %h", obs, BG); end
        n_cmp++; if (posReady !== 1'b0) begin n_err++; $display("FAIL b2b_held: got %b want 0", posReady); end
        VSin = 1'b0;
        step();
        n_cmp++; if (frameTick !== 1'b1) begin n_err++; $display("FAIL b2b_tick: got %b want 1", frameTick); end
        n_cmp++; if (posReady !== 1'b1) begin n_err++; $display("FAIL b2b_ready_after_vs: got %b want 1", posReady); end
        VSin = 1'b1;
        step();
        n_cmp++; if (posReady !== 1'b0) begin n_err++; $display("FAIL b2b_second_acc: got %b want 0", posReady); end
        posValid = 1'b0;
        run_pix(10'd100, 10'd100, 1'b1, obs);
        n_cmp++; if (obs !== SPR) begin n_err++; $display("FAIL b2b_first_vis: got %h want %h", obs, SPR); end
        run_pix(10'd200, 10'd200, 1'b1, obs);
        n_cmp++; if (obs !== BG) begin n_err++; $display("FAIL b2b_second_hidden: got %h want %h", obs, BG); end
        vs_pulse(t);
        run_pix(10'd200, 10'd200, 1'b1, obs);
        n_cmp++; if (obs !== SPR) begin n_err++; $display("FAIL b2b_second_vis: got %h want %h", obs, SPR); end
        run_pix(10'd100, 10'd100, 1'b1, obs);
        n_cmp++; if (obs !== BG) begin n_err++; $display("FAIL b2b_first_gone: got %h want %h", obs, BG); end
        n_cmp++; if (posReady !== 1'b1) begin n_err++; $display("FAIL b2b_ready_end: got %b want 1", posReady); end
    endtask

    task automatic test_reset_mid();
        logic [11:0] obs;
        logic        t;
        posX = 10'd5;
        posY = 10'd5;
        posValid = 1'b1;
        step();
        posValid = 1'b0;
        n_cmp++; if (posReady !== 1'b0) begin n_err++; $display("FAIL rstmid_pending: got %b want 0", posReady); end
        // Sprite is at (200,200), so (304,224) is background before reset
        set_pix(10'd304, 10'd224, 1'b1);
        HSin = 1'b0;
        step();
        step();
        step();
        n_cmp++; if (rgbOut !== BG) begin n_err++; $display("FAIL rstmid_pre_rgb: got %h want %h", rgbOut, BG); end
        n_cmp++; if (HS !== 1'b0) begin n_err++; $display("FAIL rstmid_pre_hs: got %b want 0", HS); end
        #2 rstVideoN = 1'b0;
        #1;
        n_cmp++; if (rgbOut !== 12'h000) begin n_err++; $display("FAIL rstmid_rgb: got %h want 000", rgbOut); end
        n_cmp++; if (HS !== 1'b1) begin n_err++; $display("FAIL rstmid_hs: got %b want 1", HS); end
        n_cmp++; if (posReady !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b want 1", posReady); end
        n_cmp++; if (sprAddr !== 12'd0) begin n_err++; $display("FAIL rstmid_addr: got %h want 000", sprAddr); end
        @(negedge ckVideo);
        rstVideoN = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            n_cmp++; if (rgbOut !== 12'h000) begin n_err++; $display("FAIL rstmid_flush_rgb[%0d]: got %h want 000", k, rgbOut); end
            n_cmp++; if (HS !== 1'b1) begin n_err++; $display("FAIL rstmid_flush_hs[%0d]: got %b want 1", k, HS); end
        end
        step();
        n_cmp++; if (rgbOut !== SPR) begin n_err++; $display("FAIL rstmid_first_pix: got %h want %h", rgbOut, SPR); end
        HSin = 1'b1;
        set_pix(10'd700, 10'd500, 1'b0);
        vs_pulse(t);
        run_pix(10'd304, 10'd224, 1'b1, obs);
        n_cmp++; if (obs !== SPR) begin n_err++; $display("FAIL rstmid_pos: got %h want %h", obs, SPR); end
        run_pix(10'd5, 10'd5, 1'b1, obs);
        n_cmp++; if (obs !== BG) begin n_err++; $display("FAIL rstmid_dropped: got %h want %h", obs, BG); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = SPR;
        test_reset();
        test_frame();
        test_clip();
        test_transparent();
        test_border();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
